// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I pipeline encodings
// Holds the ALU operation, writeback select and forward-select codes used by
// the execute stage and its ALU.
package riscv_pkg;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_e;

   typedef enum logic [1:0] {
      WB_MEM = 2'd0,
      WB_ALU = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_e;

   typedef enum logic [1:0] {
      FWD_RF    = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational RV32I integer ALU
// Ports: alu_sel_i (operation code), a_i / b_i (operands), result_o (result).
// Unassigned operation codes return zero; shifts use b_i[4:0] only.
module alu
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [3:0]      alu_sel_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] result_o
);

   logic [4:0] shamt;
   assign shamt = b_i[4:0];

   always_comb begin
      result_o = '0;
      case (alu_sel_i)
         ALU_ADD:    result_o = a_i + b_i;
         ALU_SUB:    result_o = a_i - b_i;
         ALU_SLL:    result_o = a_i << shamt;
         ALU_SLT:    result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         ALU_SLTU:   result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
         ALU_XOR:    result_o = a_i ^ b_i;
         ALU_SRL:    result_o = a_i >> shamt;
         ALU_SRA:    result_o = $signed(a_i) >>> shamt;
         ALU_OR:     result_o = a_i | b_i;
         ALU_AND:    result_o = a_i & b_i;
         ALU_PASS_B: result_o = b_i;
         default:    result_o = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32I execute stage with forwarding and EX/MEM register
// Inputs: ID/EX fields (pc_i, imm_i, RegDst/RegS1/RegS2_i, data1/2_i, ASel/BSel_i,
//   MemR/MemW/RegWEn_i, WBSel_i, ALUSel_i), MEM/WB forwarding source
//   (wb_RegWEn_i, wb_RegDst_i, wb_data_i), hazard controls (stall_i, flush_i).
// Outputs: EX/MEM register (alu_o, store_o, pc4_o, RegDst_o, MemR/MemW/RegWEn_o,
//   WBSel_o) and combinational forward selects fwd_a_o / fwd_b_o.
module ex_stage
   import riscv_pkg::*;
#(
   parameter int              XLEN    = 32,
   parameter logic [XLEN-1:0] RST_PC4 = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [4:0]      RegDst_i,
   input  logic [4:0]      RegS1_i,
   input  logic [4:0]      RegS2_i,
   input  logic [XLEN-1:0] data1_i,
   input  logic [XLEN-1:0] data2_i,
   input  logic            ASel_i,
   input  logic            BSel_i,
   input  logic            MemR_i,
   input  logic            MemW_i,
   input  logic            RegWEn_i,
   input  logic [1:0]      WBSel_i,
   input  logic [3:0]      ALUSel_i,
   input  logic            wb_RegWEn_i,
   input  logic [4:0]      wb_RegDst_i,
   input  logic [XLEN-1:0] wb_data_i,
   input  logic            stall_i,
   input  logic            flush_i,
   output logic [XLEN-1:0] alu_o,
   output logic [XLEN-1:0] store_o,
   output logic [XLEN-1:0] pc4_o,
   output logic [4:0]      RegDst_o,
   output logic            MemR_o,
   output logic            MemW_o,
   output logic            RegWEn_o,
   output logic [1:0]      WBSel_o,
   output logic [1:0]      fwd_a_o,
   output logic [1:0]      fwd_b_o
);

   logic [XLEN-1:0] alu_q, store_q, pc4_q;
   logic [4:0]      RegDst_q;
   logic            MemR_q, MemW_q, RegWEn_q;
   logic [1:0]      WBSel_q;

   logic            exmem_src_ok, memwb_src_ok;
   logic [XLEN-1:0] exmem_val;
   fwd_sel_e        fwd_a, fwd_b;
   logic [XLEN-1:0] rs1_val, rs2_val, op_a, op_b, alu_res;

   // A load in EX/MEM has no data yet; the hazard unit bubbles so it is
   // picked up from MEM/WB instead. x0 is never a source.
   assign exmem_src_ok = RegWEn_q && !MemR_q && (RegDst_q != 5'd0);
   assign memwb_src_ok = wb_RegWEn_i && (wb_RegDst_i != 5'd0);
   assign exmem_val    = (WBSel_q == WB_PC4) ? pc4_q : alu_q;

   always_comb begin
      fwd_a = FWD_RF;
      if (exmem_src_ok && (RegDst_q == RegS1_i))
         fwd_a = FWD_EXMEM;
      else if (memwb_src_ok && (wb_RegDst_i == RegS1_i))
         fwd_a = FWD_MEMWB;

      fwd_b = FWD_RF;
      if (exmem_src_ok && (RegDst_q == RegS2_i))
         fwd_b = FWD_EXMEM;
      else if (memwb_src_ok && (wb_RegDst_i == RegS2_i))
         fwd_b = FWD_MEMWB;

      case (fwd_a)
         FWD_EXMEM: rs1_val = exmem_val;
         FWD_MEMWB: rs1_val = wb_data_i;
         default:   rs1_val = data1_i;
      endcase

      case (fwd_b)
         FWD_EXMEM: rs2_val = exmem_val;
         FWD_MEMWB: rs2_val = wb_data_i;
         default:   rs2_val = data2_i;
      endcase
   end

   assign op_a = ASel_i ? pc_i  : rs1_val;
   assign op_b = BSel_i ? imm_i : rs2_val;

   alu #(.XLEN(XLEN)) u_alu (
      .alu_sel_i (ALUSel_i),
      .a_i       (op_a),
      .b_i       (op_b),
      .result_o  (alu_res)
   );

   // Flush wins over stall so a simultaneous request inserts a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_q    <= '0;
         store_q  <= '0;
         pc4_q    <= RST_PC4;
         RegDst_q <= '0;
         MemR_q   <= 1'b0;
         MemW_q   <= 1'b0;
         RegWEn_q <= 1'b0;
         WBSel_q  <= '0;
      end else if (flush_i) begin
         alu_q    <= '0;
         store_q  <= '0;
         pc4_q    <= '0;
         RegDst_q <= '0;
         MemR_q   <= 1'b0;
         MemW_q   <= 1'b0;
         RegWEn_q <= 1'b0;
         WBSel_q  <= '0;
      end else if (!stall_i) begin
         alu_q    <= alu_res;
         store_q  <= rs2_val;
         pc4_q    <= pc_i + XLEN'(32'd4);
         RegDst_q <= RegDst_i;
         MemR_q   <= MemR_i;
         MemW_q   <= MemW_i;
         RegWEn_q <= RegWEn_i;
         WBSel_q  <= WBSel_i;
      end
   end

   assign alu_o    = alu_q;
   assign store_o  = store_q;
   assign pc4_o    = pc4_q;
   assign RegDst_o = RegDst_q;
   assign MemR_o   = MemR_q;
   assign MemW_o   = MemW_q;
   assign RegWEn_o = RegWEn_q;
   assign WBSel_o  = WBSel_q;
   assign fwd_a_o  = fwd_a;
   assign fwd_b_o  = fwd_b;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage
module tb_ex_stage;

   localparam logic [31:0] RST_PC4 = 32'h0000_0040;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_i, imm_i, data1_i, data2_i, wb_data_i;
   logic [4:0]  RegDst_i, RegS1_i, RegS2_i, wb_RegDst_i;
   logic        ASel_i, BSel_i, MemR_i, MemW_i, RegWEn_i, wb_RegWEn_i;
   logic        stall_i, flush_i;
   logic [1:0]  WBSel_i;
   logic [3:0]  ALUSel_i;
   logic [31:0] alu_o, store_o, pc4_o;
   logic [4:0]  RegDst_o;
   logic        MemR_o, MemW_o, RegWEn_o;
   logic [1:0]  WBSel_o, fwd_a_o, fwd_b_o;

   ex_stage #(.XLEN(32), .RST_PC4(RST_PC4)) dut (
      .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .imm_i(imm_i),
      .RegDst_i(RegDst_i), .RegS1_i(RegS1_i), .RegS2_i(RegS2_i),
      .data1_i(data1_i), .data2_i(data2_i), .ASel_i(ASel_i), .BSel_i(BSel_i),
      .MemR_i(MemR_i), .MemW_i(MemW_i), .RegWEn_i(RegWEn_i), .WBSel_i(WBSel_i),
      .ALUSel_i(ALUSel_i), .wb_RegWEn_i(wb_RegWEn_i), .wb_RegDst_i(wb_RegDst_i),
      .wb_data_i(wb_data_i), .stall_i(stall_i), .flush_i(flush_i),
      .alu_o(alu_o), .store_o(store_o), .pc4_o(pc4_o), .RegDst_o(RegDst_o),
      .MemR_o(MemR_o), .MemW_o(MemW_o), .RegWEn_o(RegWEn_o), .WBSel_o(WBSel_o),
      .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference copy of what the EX/MEM register should hold.
   logic [31:0] m_alu, m_store, m_pc4;
   logic [4:0]  m_rd;
   logic        m_memr, m_memw, m_wen;
   logic [1:0]  m_wbsel;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int unsigned sh;
      logic [31:0] r;
      sh = b % 32;
      r  = 32'd0;
      if      (op == 4'd0)  r = a + b;
      else if (op == 4'd1)  r = a + (~b) + 32'd1;
      else if (op == 4'd2)  r = a * (32'd1 << sh);
      else if (op == 4'd3)  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      else if (op == 4'd4)  r = ({1'b0, a} < {1'b0, b}) ? 32'd1 : 32'd0;
      else if (op == 4'd5)  r = a ^ b;
      else if (op == 4'd6)  r = a / (32'd1 << sh);
      else if (op == 4'd7)  r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      else if (op == 4'd8)  r = a | b;
      else if (op == 4'd9)  r = a & b;
      else if (op == 4'd10) r = b;
      return r;
   endfunction

   // Which stage supplies register rs, given the model's EX/MEM view.
   function automatic logic [1:0] ref_src(input logic [4:0] rs);
      if (rs != 0 && m_wen && !m_memr && m_rd == rs) return 2'd1;
      if (rs != 0 && wb_RegWEn_i && wb_RegDst_i == rs) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [31:0] ref_val(input logic [1:0] src, input logic [31:0] rf);
      if (src == 2'd1) return (m_wbsel == 2'd2) ? m_pc4 : m_alu;
      if (src == 2'd2) return wb_data_i;
      return rf;
   endfunction

   task automatic model_reset();
      m_alu = 0; m_store = 0; m_pc4 = RST_PC4; m_rd = 0;
      m_memr = 0; m_memw = 0; m_wen = 0; m_wbsel = 0;
   endtask

   task automatic check_outs(input string tag);
      chk({tag, ".alu"},    alu_o,            m_alu);
      chk({tag, ".store"},  store_o,          m_store);
      chk({tag, ".pc4"},    pc4_o,            m_pc4);
      chk({tag, ".rd"},     {27'd0, RegDst_o}, {27'd0, m_rd});
      chk({tag, ".memr"},   {31'd0, MemR_o},   {31'd0, m_memr});
      chk({tag, ".memw"},   {31'd0, MemW_o},   {31'd0, m_memw});
      chk({tag, ".wen"},    {31'd0, RegWEn_o}, {31'd0, m_wen});
      chk({tag, ".wbsel"},  {30'd0, WBSel_o},  {30'd0, m_wbsel});
   endtask

   // Checks forward selects, clocks once, then checks the registered outputs.
   task automatic cycle(input string tag);
      logic [1:0]  sa, sb;
      logic [31:0] va, vb, a, b, res;
      #1;
      sa = ref_src(RegS1_i);
      sb = ref_src(RegS2_i);
      va = ref_val(sa, data1_i);
      vb = ref_val(sb, data2_i);
      chk({tag, ".fwd_a"}, {30'd0, fwd_a_o}, {30'd0, sa});
      chk({tag, ".fwd_b"}, {30'd0, fwd_b_o}, {30'd0, sb});
      a   = ASel_i ? pc_i : va;
      b   = BSel_i ? imm_i : vb;
      res = ref_alu(ALUSel_i, a, b);
      @(posedge clk);
      if (flush_i) begin
         m_alu = 0; m_store = 0; m_pc4 = 0; m_rd = 0;
         m_memr = 0; m_memw = 0; m_wen = 0; m_wbsel = 0;
      end else if (!stall_i) begin
         m_alu = res; m_store = vb; m_pc4 = pc_i + 32'd4; m_rd = RegDst_i;
         m_memr = MemR_i; m_memw = MemW_i; m_wen = RegWEn_i; m_wbsel = WBSel_i;
      end
      #1;
      check_outs(tag);
   endtask

   task automatic set_op(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] d1, input logic [31:0] d2,
                         input logic bsel, input logic [31:0] imm);
      ALUSel_i = op; RegDst_i = rd; RegS1_i = rs1; RegS2_i = rs2;
      data1_i = d1; data2_i = d2; BSel_i = bsel; imm_i = imm;
      ASel_i = 0; MemR_i = 0; MemW_i = 0; RegWEn_i = 1; WBSel_i = 2'd1;
      pc_i = pc_i + 32'd4;
   endtask

   initial begin
      rst_n = 0; pc_i = 32'h1000; imm_i = 0; data1_i = 0; data2_i = 0; wb_data_i = 0;
      RegDst_i = 0; RegS1_i = 0; RegS2_i = 0; wb_RegDst_i = 0;
      ASel_i = 0; BSel_i = 0; MemR_i = 0; MemW_i = 0; RegWEn_i = 0; wb_RegWEn_i = 0;
      stall_i = 0; flush_i = 0; WBSel_i = 0; ALUSel_i = 0;
      model_reset();

      // reset state
      #12;
      check_outs("reset");
      @(posedge clk); #1;
      rst_n = 1;

      // back-to-back ADD dependency
      set_op(4'd0, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 1'b0, 32'd0);
      cycle("add1");
      chk("add1_val", alu_o, 32'd12);
      set_op(4'd0, 5'd4, 5'd3, 5'd9, 32'd0, 32'd0, 1'b1, 32'd1);
      #1;
      chk("add2_fwd_a", {30'd0, fwd_a_o}, 32'd1);
      cycle("add2");
      chk("add2_val", alu_o, 32'd13);

      // EX/MEM beats MEM/WB
      set_op(4'd0, 5'd3, 5'd10, 5'd11, 32'd20, 32'd0, 1'b0, 32'd0);
      cycle("dh_prod");
      set_op(4'd0, 5'd6, 5'd3, 5'd12, 32'd0, 32'd0, 1'b1, 32'd0);
      wb_RegWEn_i = 1; wb_RegDst_i = 5'd3; wb_data_i = 32'd99;
      #1;
      chk("dh_fwd_a", {30'd0, fwd_a_o}, 32'd1);
      cycle("dh_cons");
      chk("dh_val", alu_o, 32'd20);
      wb_RegWEn_i = 0;

      // x0 is never forwarded
      set_op(4'd10, 5'd0, 5'd13, 5'd14, 32'd0, 32'd0, 1'b1, 32'h0000_DEAD);
      cycle("x0_prod");
      set_op(4'd0, 5'd7, 5'd0, 5'd15, 32'd0, 32'd0, 1'b1, 32'd0);
      #1;
      chk("x0_fwd_a", {30'd0, fwd_a_o}, 32'd0);
      cycle("x0_cons");
      chk("x0_val", alu_o, 32'd0);

      // ALU edge cases
      set_op(4'd1, 5'd20, 5'd21, 5'd22, 32'd0, 32'd1, 1'b0, 32'd0);
      cycle("sub");  chk("sub_val", alu_o, 32'hFFFF_FFFF);
      set_op(4'd7, 5'd20, 5'd21, 5'd22, 32'h8000_0000, 32'd0, 1'b1, 32'd4);
      cycle("sra");  chk("sra_val", alu_o, 32'hF800_0000);
      set_op(4'd3, 5'd20, 5'd21, 5'd22, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd1);
      cycle("slt");  chk("slt_val", alu_o, 32'd1);
      set_op(4'd4, 5'd20, 5'd21, 5'd22, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd1);
      cycle("sltu"); chk("sltu_val", alu_o, 32'd0);
      set_op(4'd2, 5'd20, 5'd21, 5'd22, 32'd1, 32'd0, 1'b1, 32'd33);
      cycle("sll");  chk("sll_val", alu_o, 32'd2);

      // stall holds, then stall+flush bubbles
      set_op(4'd0, 5'd5, 5'd23, 5'd24, 32'd4, 32'd6, 1'b0, 32'd0);
      cycle("st_load"); chk("st_load_val", alu_o, 32'd10);
      stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         set_op(4'd5, 5'd8, 5'd5, 5'd25, $urandom, $urandom, 1'b0, 32'd0);
         cycle("stall"); chk("stall_hold", alu_o, 32'd10);
      end
      flush_i = 1;
      cycle("flush");
      chk("flush_wen", {31'd0, RegWEn_o}, 32'd0);
      chk("flush_memw", {31'd0, MemW_o}, 32'd0);
      chk("flush_alu", alu_o, 32'd0);
      stall_i = 0; flush_i = 0;

      // randomized traffic with dense register reuse
      for (int i = 0; i < 300; i++) begin
         pc_i = $urandom; imm_i = $urandom; data1_i = $urandom; data2_i = $urandom;
         wb_data_i = $urandom;
         RegDst_i = 5'($urandom_range(0, 7)); RegS1_i = 5'($urandom_range(0, 7));
         RegS2_i = 5'($urandom_range(0, 7)); wb_RegDst_i = 5'($urandom_range(0, 7));
         ASel_i = 1'($urandom); BSel_i = 1'($urandom); MemR_i = 1'($urandom);
         MemW_i = 1'($urandom); RegWEn_i = 1'($urandom); wb_RegWEn_i = 1'($urandom);
         WBSel_i = 2'($urandom); ALUSel_i = 4'($urandom);
         if ($urandom_range(0, 99) < 8) data1_i = 32'h8000_0000;
         stall_i = ($urandom_range(0, 99) < 15);
         flush_i = ($urandom_range(0, 99) < 8);
         cycle("rand");
      end
      stall_i = 0; flush_i = 0;

      // asynchronous reset between edges
      set_op(4'd0, 5'd9, 5'd26, 5'd27, 32'd1, 32'd2, 1'b0, 32'd0);
      cycle("pre_rst");
      chk("pre_rst_wen", {31'd0, RegWEn_o}, 32'd1);
      #2;
      rst_n = 0;
      #1;
      model_reset();
      check_outs("async_rst");
      chk("async_rst_pc4", pc4_o, RST_PC4);
      #1;
      rst_n = 1;
      set_op(4'd0, 5'd9, 5'd26, 5'd27, 32'd3, 32'd4, 1'b0, 32'd0);
      cycle("post_rst");
      chk("post_rst_val", alu_o, 32'd7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage RV32I pipeline. It consumes the registered outputs of the ID/EX pipeline register and resolves operand forwarding from the EX/MEM and MEM/WB stages. It computes the ALU result and registers the result plus control into an internal EX/MEM register, which feeds the memory stage. Stall and flush controls from the hazard unit hold or bubble the EX/MEM register.

## Interface
Parameters:
- XLEN, 32, datapath width
- RST_PC4, 0, reset value of pc4_o

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pc_i  in  XLEN  PC of the instruction in EX
- imm_i  in  XLEN  sign-extended immediate
- RegDst_i / RegS1_i / RegS2_i  in  5 each  rd / rs1 / rs2
- data1_i / data2_i  in  XLEN  register-file read data for rs1 / rs2
- ASel_i  in  1  operand A select: 0 = rs1 (forwarded), 1 = pc_i
- BSel_i  in  1  operand B select: 0 = rs2 (forwarded), 1 = imm_i
- MemR_i / MemW_i / RegWEn_i  in  1 each  load / store / register write
- WBSel_i  in  2  writeback select: 0 = mem, 1 = ALU, 2 = pc+4, 3 = reserved
- ALUSel_i  in  4  ALU operation
- wb_RegWEn_i  in  1  MEM/WB write enable
- wb_RegDst_i  in  5  MEM/WB rd
- wb_data_i  in  XLEN  MEM/WB final writeback value
- stall_i  in  1  hold the EX/MEM register
- flush_i  in  1  load a bubble into the EX/MEM register
- alu_o  out  XLEN  registered ALU result (memory address for loads and stores)
- store_o  out  XLEN  registered forwarded rs2 value (store data)
- pc4_o  out  XLEN  registered pc_i + 4
- RegDst_o  out  5  registered rd
- MemR_o / MemW_o / RegWEn_o  out  1 each  registered control
- WBSel_o  out  2  registered writeback select
- fwd_a_o / fwd_b_o  out  2 each  combinational forward select for debug: 0 = regfile, 1 = EX/MEM, 2 = MEM/WB

## Operation
Forwarding (combinational, applied per source rsX):
- EX/MEM match: RegWEn_o = 1, MemR_o = 0, RegDst_o ≠ 0 and RegDst_o = rsX. Forward value is pc4_o if WBSel_o = 2, otherwise alu_o.
- Otherwise, MEM/WB match: wb_RegWEn_i = 1, wb_RegDst_i ≠ 0 and wb_RegDst_i = rsX. Forward value is wb_data_i.
- Otherwise the register-file value is used.
- EX/MEM takes priority over MEM/WB.
- A load in EX/MEM is never forwarded. The upstream hazard unit inserts one bubble for a load-use dependency, which leaves the load in MEM/WB.

ALU (A, B 32-bit, modulo-2^32):
- ALUSel encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B (LUI).
- Codes 11–15 produce 0.
- Shift amount is B[4:0].
- SLT and SLTU produce 0 or 1, zero-extended.

EX/MEM register update priority:
- rst_n = 0: every output is 0, except pc4_o = RST_PC4. Reset is asynchronous and may occur mid-operation; it discards all in-flight state.
- flush_i = 1: bubble. MemR_o, MemW_o, RegWEn_o, WBSel_o, RegDst_o are 0; the data outputs alu_o, store_o, pc4_o are 0. Flush overrides stall.
- stall_i = 1: all outputs hold.
- Otherwise: load the computed values.

Stall behaviour: during a stall the ID/EX inputs are held upstream. Forwarding keeps using the held EX/MEM contents, so the result is consistent when the stall releases.

## Timing
- Latency: 1 cycle. Inputs valid before edge n appear on the outputs after edge n.
- Forwarding path: combinational from alu_o, pc4_o, RegDst_o and the wb_* inputs into the ALU. This is the stage critical path.
- fwd_a_o and fwd_b_o reflect the current inputs combinationally.
- Reset deassertion: the first update occurs on the first rising edge with rst_n = 1.
- Simultaneous stall_i and flush_i: bubble is loaded.
- rd = x0 is never a forwarding source, even when RegWEn is set.

## Structure
- Shared package riscv_pkg holds:
  - ALUSel codes as an enum alu_op_e.
  - WBSel codes as an enum wb_sel_e: WB_MEM, WB_ALU, WB_PC4.
  - Forward-select codes as an enum fwd_sel_e.
- One sub-module, alu: purely combinational, ALUSel/A/B in, result out.
- The forwarding muxes and the EX/MEM register stay in ex_stage.

## Test plan
- ADD back-to-back dependency: instruction 1 ADD with rs1 = 5, rs2 = 7 → x3; next instruction uses rs1 = x3, imm = 1, BSel = 1. Required: fwd_a_o = 1, second alu_o = 13.
- Double hazard priority: x3 in EX/MEM = 20 and in MEM/WB (wb_data_i) = 99; consumer uses rs1 = x3. Required: fwd_a_o = 1, operand A = 20.
- x0 guard: RegDst_o = 0 with RegWEn_o = 1 and alu_o = 0xDEAD; consumer reads x0 with data1_i = 0. Required: fwd_a_o = 0, operand A = 0.
- ALU edge cases:
  - SUB 0 − 1 → alu_o = 0xFFFFFFFF.
  - SRA 0x80000000 by 4 → alu_o = 0xF8000000.
  - SLT −1 < 1 → alu_o = 1.
  - SLTU 0xFFFFFFFF < 1 → alu_o = 0.
  - SLL with B = 33 shifts by 1.
- Stall then flush: load ADD result 10; assert stall_i for 3 cycles with new inputs applied → alu_o stays 10. Then assert stall_i and flush_i together → RegWEn_o = MemW_o = 0, alu_o = 0.
- Async reset mid-stream: drop rst_n between clock edges while RegWEn_o = 1. Required: all outputs go 0 immediately, with no clock edge; pc4_o = RST_PC4.
